// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: EX redirect, IMEM loader write port, decode-side
// handshake and the misaligned-target fault pulse.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;
  logic [31:0] redirect_rs1;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic        fetch_fault;

  // Environment side: drives redirects, IMEM writes and decode ready.
  modport master (
    output redirect_valid, redirect_kind, redirect_pc, redirect_imm, redirect_rs1,
    output imem_we, imem_waddr, imem_wdata, out_ready,
    input  out_valid, out_instr, out_pc, out_npc, fetch_fault
  );

  // Fetch unit side.
  modport slave (
    input  redirect_valid, redirect_kind, redirect_pc, redirect_imm, redirect_rs1,
    input  imem_we, imem_waddr, imem_wdata, out_ready,
    output out_valid, out_instr, out_pc, out_npc, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, synchronous-read IMEM and a prefetch
// FIFO feeding decode over valid/ready. Redirects flush the FIFO and drop any
// in-flight read; misaligned targets raise a one-cycle fault pulse.
module fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  fetch_unit_if.slave bus
);
  localparam int unsigned IdxW = $clog2(IMEM_DEPTH);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [31:0]     mem_q [IMEM_DEPTH];
  logic [31:0]     rd_data_q, rd_pc_q;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q [FIFO_DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     fpc_q, fpc_d;
  logic            inflight_q, inflight_d;
  logic            fault_q, fault_d;
  logic [31:0]     target;
  logic [OccW-1:0] occ;
  logic            valid, push, pop, issue;
  logic            unused_waddr;

  assign unused_waddr = ^{bus.imem_waddr[31:IdxW+2], bus.imem_waddr[1:0]};

  assign valid = (count_q != '0);
  // Count plus in-flight read, so the issue gate always reserves a FIFO slot.
  assign occ   = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign pop   = valid && bus.out_ready && !bus.redirect_valid;
  assign push  = inflight_q && !bus.redirect_valid;
  assign issue = !bus.redirect_valid &&
                 ((occ < OccW'(FIFO_DEPTH)) || ((occ == OccW'(FIFO_DEPTH)) && pop));

  // Redirect target; kind 2'b11 falls through to the branch form.
  always_comb begin
    target = bus.redirect_pc + bus.redirect_imm;
    if (bus.redirect_kind == 2'b10) begin
      target = (bus.redirect_rs1 + bus.redirect_imm) & 32'hffff_fffe;
    end
  end

  // IMEM: read-before-write falls out of non-blocking update of the array.
  always_ff @(posedge clk) begin
    if (bus.imem_we) mem_q[bus.imem_waddr[IdxW+1:2]] <= bus.imem_wdata;
    if (issue) begin
      rd_data_q <= mem_q[fpc_q[IdxW+1:2]];
      rd_pc_q   <= fpc_q;
    end
  end

  // FIFO storage write; data is qualified by count so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[tail_q] <= rd_data_q;
      fifo_pc_q[tail_q]    <= rd_pc_q;
    end
  end

  // Next-state for PC, FIFO pointers/count, in-flight flag and fault pulse.
  always_comb begin
    fpc_d      = fpc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = 1'b0;
    fault_d    = 1'b0;
    if (bus.redirect_valid) begin
      fpc_d   = target & 32'hffff_fffc;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      fault_d = target[1];
    end else begin
      if (issue) begin
        fpc_d      = fpc_q + 32'd4;
        inflight_d = 1'b1;
      end
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset leaves IMEM contents untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.out_valid   = valid;
  assign bus.out_instr   = valid ? fifo_instr_q[head_q] : '0;
  assign bus.out_pc      = valid ? fifo_pc_q[head_q] : '0;
  assign bus.out_npc     = valid ? fifo_pc_q[head_q] + 32'd4 : '0;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 16-word IMEM so index wrap is reachable.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit #(
    .IMEM_DEPTH(16),
    .FIFO_DEPTH(4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ready;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  vec_t        vecs [24];
  logic [31:0] tb_mem [16];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [3:0] idx;
    idx = pc[5:2];
    return tb_mem[idx];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string name, input bit ev, input logic [31:0] epc,
                       input logic [31:0] einstr, input bit ef);
    cmp({name, ".valid"}, {31'b0, bus.out_valid}, {31'b0, ev});
    cmp({name, ".pc"},    bus.out_pc,    ev ? epc : 32'h0);
    cmp({name, ".npc"},   bus.out_npc,   ev ? epc + 32'd4 : 32'h0);
    cmp({name, ".instr"}, bus.out_instr, ev ? einstr : 32'h0);
    cmp({name, ".fault"}, {31'b0, bus.fetch_fault}, {31'b0, ef});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check this cycle's outputs, advance one cycle, then drop one-cycle pulses.
  task automatic step(input string name, input bit ev, input logic [31:0] epc,
                      input logic [31:0] einstr, input bit ef);
    #1;
    check(name, ev, epc, einstr, ef);
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_we        = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] kind, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1);
    bus.redirect_valid = 1'b1;
    bus.redirect_kind  = kind;
    bus.redirect_pc    = pc;
    bus.redirect_imm   = imm;
    bus.redirect_rs1   = rs1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_kind  = 2'b00;
    bus.redirect_pc    = '0;
    bus.redirect_imm   = '0;
    bus.redirect_rs1   = '0;
    bus.imem_we        = 1'b0;
    bus.imem_waddr     = '0;
    bus.imem_wdata     = '0;
    bus.out_ready      = 1'b0;

    tb_mem[0] = 32'h0062a023;
    tb_mem[1] = 32'h0002a383;
    tb_mem[2] = 32'h002384b3;
    tb_mem[3] = 32'h00000013;
    for (int i = 4; i < 16; i++) tb_mem[i] = 32'h1000_0000 + 32'(i);

    // Stream from reset, mid-stream reset, 10 cycles of backpressure, release.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h04};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h08};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0C};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h10};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h00};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h00};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h00};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'h04};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 32'h08};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 32'h0C};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 32'h10};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 32'h14};

    // Load IMEM while held in reset.
    for (int i = 0; i < 16; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 32'(i) * 32'd4;
      bus.imem_wdata = tb_mem[i];
      tick();
    end
    bus.imem_we = 1'b0;

    for (int i = 0; i < 24; i++) begin
      rst           = vecs[i].rst;
      bus.out_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, word_at(vecs[i].epc), 1'b0);
      tick();
    end
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    // Branch back by 8 while popping with a read in flight: flush, target 0x08.
    redirect(2'b00, 32'h10, 32'hFFFF_FFF8, 32'h0);
    step("br_cyc",   1'b1, 32'h18, word_at(32'h18), 1'b0);
    step("br_r1",    1'b0, 32'h0,  32'h0,           1'b0);
    step("br_r2",    1'b0, 32'h0,  32'h0,           1'b0);
    step("br_tgt",   1'b1, 32'h08, word_at(32'h08), 1'b0);

    // JALR to 0x22: fault once, fetch from 0x20.
    redirect(2'b10, 32'h0, 32'h1, 32'h21);
    step("jalr_cyc", 1'b1, 32'h0C, word_at(32'h0C), 1'b0);
    step("jalr_r1",  1'b0, 32'h0,  32'h0,           1'b1);
    step("jalr_r2",  1'b0, 32'h0,  32'h0,           1'b0);
    step("jalr_tgt", 1'b1, 32'h20, word_at(32'h20), 1'b0);

    // JAL to 0x04, then write 0x0C in the same cycle 0x0C is issued.
    redirect(2'b01, 32'h0, 32'h4, 32'h0);
    step("jal_cyc",  1'b1, 32'h24, word_at(32'h24), 1'b0);
    step("jal_r1",   1'b0, 32'h0,  32'h0,           1'b0);
    step("jal_r2",   1'b0, 32'h0,  32'h0,           1'b0);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 32'h0C;
    bus.imem_wdata = 32'hDEAD_BEEF;
    step("rbw_04",   1'b1, 32'h04, 32'h0002a383,    1'b0);
    tb_mem[3] = 32'hDEAD_BEEF;
    step("rbw_08",   1'b1, 32'h08, 32'h002384b3,    1'b0);
    step("rbw_old",  1'b1, 32'h0C, 32'h00000013,    1'b0);

    // Kind 2'b11 behaves as a branch: back to 0x0C, now sees the new word.
    redirect(2'b11, 32'h0C, 32'h0, 32'hFFFF_FFFF);
    step("k3_cyc",   1'b1, 32'h10, word_at(32'h10), 1'b0);
    step("k3_r1",    1'b0, 32'h0,  32'h0,           1'b0);
    step("k3_r2",    1'b0, 32'h0,  32'h0,           1'b0);
    step("rbw_new",  1'b1, 32'h0C, 32'hDEAD_BEEF,   1'b0);

    // Target 0x40 wraps to IMEM index 0 but keeps its full PC.
    redirect(2'b00, 32'h30, 32'h10, 32'h0);
    step("wrap_cyc", 1'b1, 32'h10, word_at(32'h10), 1'b0);
    step("wrap_r1",  1'b0, 32'h0,  32'h0,           1'b0);
    step("wrap_r2",  1'b0, 32'h0,  32'h0,           1'b0);
    step("wrap_tgt", 1'b1, 32'h40, 32'h0062a023,    1'b0);

    // Back-to-back: misaligned 0x32 then 0x10; the second wins.
    redirect(2'b00, 32'h0, 32'h32, 32'h0);
    step("b2b_cyc",  1'b1, 32'h44, 32'h0002a383,    1'b0);
    redirect(2'b01, 32'h100, 32'hFFFF_FF10, 32'h0);
    step("b2b_r1",   1'b0, 32'h0,  32'h0,           1'b1);
    step("b2b_r2",   1'b0, 32'h0,  32'h0,           1'b0);
    step("b2b_r3",   1'b0, 32'h0,  32'h0,           1'b0);
    step("b2b_tgt",  1'b1, 32'h10, word_at(32'h10), 1'b0);
    step("b2b_nxt",  1'b1, 32'h14, word_at(32'h14), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
